adc_lane_formatter: RTL
=======================

Name: adc_lane_formatter

Overview:
- Parametrised ADC sample formatter between the serdes deserialiser output and the ADC-to-datamover stage.
- Per-lane conversion from offset binary to two's complement, with per-lane polarity correction.
- Channel-mode dependent de-interleave, so that each channel's samples land in contiguous output lanes.
- Mode changes are synchronised, applied atomically with a blanking window, and flagged with a start-of-frame pulse.

Parameters:
- SAMPLE_W, 8: bits per sample/lane.
- NUM_LANES, 8: lanes per beat; must be divisible by 4.
- INV_MASK, 8'b11101100: per lane, 1 = lane is P/N swapped (keep MSB, invert bits [SAMPLE_W-2:0]); 0 = invert MSB only.
- FLUSH_BEATS, 4: valid input beats suppressed after a mode change (1..255).

Ports:
- clk  in  1  sample clock (ADC divclk domain)
- rst  in  1  asynchronous, active-high reset
- in_data  in  NUM_LANES*SAMPLE_W  raw deserialised lanes; lane i = bits [i*SAMPLE_W +: SAMPLE_W]
- in_valid  in  1  beat qualifier (serdes ready)
- ch_mode_async  in  2  requested mode from the GPIO domain: 0 = 1 channel, 1 = 2 channels, 2/3 = 4 channels
- out_data  out  NUM_LANES*SAMPLE_W  formatted, reordered beat
- out_valid  out  1  beat qualifier
- out_sof  out  1  one-cycle pulse on the first valid beat after reset or after a mode change
- out_ch_mode  out  2  mode applied to the current out_data
- mode_changes  out  8  wrapping count of applied mode changes

Behaviour:
- Reset (async assert, sync release):
  - out_data = 0, out_valid = 0, out_sof = 0, out_ch_mode = 0, mode_changes = 0.
  - Sync flops = 0, applied mode = 0, blank counter = FLUSH_BEATS, sof_pending = 1.
- Mode sync:
  - ch_mode_async passes through 3 flops per bit.
  - Code 3 is normalised to 2 before comparison.
- Mode change detect:
  - When synced mode != applied mode: applied mode updates next cycle, blank counter reloads FLUSH_BEATS, sof_pending = 1, mode_changes increments (wraps 255 -> 0).
  - A change arriving during blanking reloads the counter again.
- Blanking:
  - While blank counter != 0, each cycle with in_valid = 1 decrements the counter.
  - That beat is dropped: stage-1 valid = 0.
  - in_valid = 0 holds the counter.
- Stage 1 (registered):
  - Per lane: INV_MASK bit = 1 gives {d[MSB], ~d[MSB-1:0]}; otherwise {~d[MSB], d[MSB-1:0]}.
  - Valid = in_valid & (blank == 0).
  - The applied mode is captured alongside the data.
- Stage 2 (registered):
  - C = 1/2/4 from the captured mode; S = NUM_LANES/C.
  - Output lane c*S + s takes stage-1 lane s*C + c.
  - C = 1 is identity.
- Latency: in_valid to out_valid = 2 cycles; no backpressure.
- out_data holds its last value when out_valid = 0.
- out_sof asserts with the first stage-2 valid beat while sof_pending = 1. sof_pending clears on that beat.
- out_ch_mode is registered with out_data, so it always matches its data even across a change boundary.
- in_valid deasserting mid-stream: bubbles propagate unchanged. No reordering across beats.

Optional Feature:
- Macro ADC_FMT_RAMP_EN.
- When defined:
  - An internal SAMPLE_W-bit counter, reset to 0, increments on each in_valid beat.
  - Stage 1 replaces every lane with counter value + lane index, bypassing polarity conversion.
  - Blanking, reorder and sof behave normally.
- When undefined: no counter logic; data path as above.

Decomposition:
- Package adc_fmt_pkg:
  - Mode encodings MODE_1CH = 0, MODE_2CH = 1, MODE_4CH = 2.
  - Function ch_count(mode) returning 1/2/4.
  - Function lane_src(j, C, NUM_LANES) implementing the reorder index.
- Sub-module adc_fmt_mode_sync: 3-flop synchroniser, code normalisation and change-detect pulse.

Test Plan:
- Polarity: INV_MASK default, all lanes 0x80 -> after 2 cycles lanes 2,3,5,6,7 = 0xFF and lanes 0,1,4 = 0x00. Input 0x00 -> 0x7F / 0x80 respectively.
- Reorder:
  - Setup: INV_MASK = 0, lanes i = 0x80 + i.
  - Mode 0 -> 0x0706050403020100.
  - Mode 1 -> 0x0705030106040200.
  - Mode 2 or 3 -> 0x0703060205010400.
- Mode change:
  - Stimulus: continuous in_valid, ch_mode_async 0 -> 2.
  - Exactly FLUSH_BEATS = 4 beats are dropped.
  - First valid beat carries out_sof = 1 and out_ch_mode = 2; mode_changes = 1.
- Blanking with gaps: in_valid toggling 1010... during a change -> counter decrements only on high cycles; 4 valid beats dropped in total.
- Reset mid-stream: assert rst while out_valid = 1 -> all outputs 0 immediately. After release, the first 4 valid beats are dropped, then out_sof = 1.
- Counter wrap: force 256 mode changes -> mode_changes wraps to 0.

Source files
------------

// File: rtl/adc_fmt_pkg.sv
// ADC lane formatter shared definitions: channel-mode encodings and reorder helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package adc_fmt_pkg;

    // Channel-mode encodings. Code 3 is folded onto MODE_4CH by the synchroniser.
    localparam logic [1:0] MODE_1CH = 2'd0;
    localparam logic [1:0] MODE_2CH = 2'd1;
    localparam logic [1:0] MODE_4CH = 2'd2;

    // Number of interleaved channels carried by a beat in the given mode.
    function automatic int ch_count(input logic [1:0] mode);
        case (mode)
            MODE_1CH: return 1;
            MODE_2CH: return 2;
            default:  return 4;
        endcase
    endfunction

    // Source lane for output lane j when C channels are interleaved over n lanes.
    // Output lane c*S + s takes input lane s*C + c, with S = n / C.
    function automatic int lane_src(input int j, input int c, input int n);
        int s_per_ch;
        s_per_ch = n / c;
        return (j % s_per_ch) * c + (j / s_per_ch);
    endfunction

endpackage

// File: rtl/adc_fmt_mode_sync.sv
// Channel-mode synchroniser: 3-flop sync per bit, folds code 3 onto 4-channel mode,
// holds the applied mode and flags a one-cycle change when the synced mode differs.
// Latency: 3 cycles to the synced value, applied mode follows one cycle after o_change.
// Backpressure: none.
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_mode_async   requested mode from the slow GPIO domain
//   o_mode         applied mode
//   o_change       high for one cycle when the synced mode differs from o_mode
module adc_fmt_mode_sync
    import adc_fmt_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_mode_async,
    output logic [1:0] o_mode,
    output logic       o_change
);

    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_sync3;
    logic [1:0] r_applied;
    logic [1:0] w_norm;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 2'd0;
            r_sync2 <= 2'd0;
            r_sync3 <= 2'd0;
        end else begin
            r_sync1 <= i_mode_async;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_norm   = (r_sync3 == 2'd3) ? MODE_4CH : r_sync3;
    assign o_change = (w_norm != r_applied);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_applied <= MODE_1CH;
        end else if (o_change) begin
            r_applied <= w_norm;
        end
    end

    assign o_mode = r_applied;

endmodule

// File: rtl/adc_lane_formatter.sv
// ADC lane formatter: offset-binary to two's complement with per-lane P/N fix-up,
// then channel de-interleave so each channel's samples sit in contiguous lanes.
// Latency: 2 cycles in_valid -> out_valid. Backpressure: none; beats are never stalled.
//
// Ports:
//   clk, rst        sample clock, asynchronous active-high reset
//   in_data/in_valid   raw deserialised lanes (lane i = bits [i*SAMPLE_W +: SAMPLE_W])
//   ch_mode_async   requested channel mode (0 = 1ch, 1 = 2ch, 2/3 = 4ch), any domain
//   out_data/out_valid formatted, reordered beat; out_data holds while out_valid = 0
//   out_sof         pulse on first valid beat after reset or a mode change
//   out_ch_mode     mode that was applied to the beat on out_data
//   mode_changes    wrapping count of applied mode changes
// Optional: define ADC_FMT_RAMP_EN to replace the lanes with a counting ramp
// (counter + lane index) for link bring-up; blanking, reorder and sof are unchanged.
// NUM_LANES must be a multiple of 4 so every mode splits the beat evenly.
module adc_lane_formatter
    import adc_fmt_pkg::*;
#(
    parameter int                     SAMPLE_W    = 8,
    parameter int                     NUM_LANES   = 8,
    parameter logic [NUM_LANES-1:0]   INV_MASK    = 8'b11101100,
    parameter int                     FLUSH_BEATS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LANES*SAMPLE_W-1:0] in_data,
    input  logic                          in_valid,
    input  logic [1:0]                    ch_mode_async,
    output logic [NUM_LANES*SAMPLE_W-1:0] out_data,
    output logic                          out_valid,
    output logic                          out_sof,
    output logic [1:0]                    out_ch_mode,
    output logic [7:0]                    mode_changes
);

    localparam int         BEAT_W    = NUM_LANES * SAMPLE_W;
    localparam logic [7:0] BLANK_LD  = 8'(FLUSH_BEATS);

    logic [1:0]          w_mode;
    logic                w_change;
    logic                w_blank_zero;
    logic                w_accept;
    logic [BEAT_W-1:0]   w_s1_src;
    logic [BEAT_W-1:0]   w_reorder;
    logic [2:0]          w_ch_cnt;
    logic [SAMPLE_W-1:0] w_s1_lane [NUM_LANES];
    logic [SAMPLE_W-1:0] w_re_lane [NUM_LANES];

    logic [7:0]          r_blank;
    logic                r_sof_pend;
    logic [7:0]          r_mode_cnt;
    logic [BEAT_W-1:0]   r_s1_dat;
    logic                r_s1_vld;
    logic                r_s1_sof;
    logic [1:0]          r_s1_mode;
    logic [BEAT_W-1:0]   r_out_dat;
    logic                r_out_vld;
    logic                r_out_sof;
    logic [1:0]          r_out_mode;

    adc_fmt_mode_sync u_mode_sync (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mode_async (ch_mode_async),
        .o_mode       (w_mode),
        .o_change     (w_change)
    );

    // ---------------- blanking / sof / change counter ----------------
    assign w_blank_zero = (r_blank == 8'd0);
    assign w_accept     = in_valid & w_blank_zero;

    // Only valid beats consume the blanking window; a new change restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blank <= BLANK_LD;
        end else if (w_change) begin
            r_blank <= BLANK_LD;
        end else if (in_valid && !w_blank_zero) begin
            r_blank <= r_blank - 8'd1;
        end
    end

    // sof is tagged at stage-1 acceptance so a beat already in flight with the
    // old mode cannot claim the pulse meant for the new mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sof_pend <= 1'b1;
        end else if (w_change) begin
            r_sof_pend <= 1'b1;
        end else if (w_accept) begin
            r_sof_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_cnt <= 8'd0;
        end else if (w_change) begin
            r_mode_cnt <= r_mode_cnt + 8'd1;
        end
    end

    // ---------------- stage 1 source: polarity fix or ramp ----------------
`ifdef ADC_FMT_RAMP_EN
    logic [SAMPLE_W-1:0] r_ramp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ramp <= '0;
        end else if (in_valid) begin
            r_ramp <= r_ramp + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_ramp
        assign w_s1_lane[gi] = r_ramp + SAMPLE_W'(gi);
    end
`else
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_pol
        if (INV_MASK[gi]) begin : g_swap
            // P/N swapped lane: the whole word is inverted, so flipping the
            // low bits alone yields two's complement.
            assign w_s1_lane[gi] = {in_data[gi*SAMPLE_W + SAMPLE_W-1],
                                    ~in_data[gi*SAMPLE_W +: SAMPLE_W-1]};
        end else begin : g_norm
            assign w_s1_lane[gi] = {~in_data[gi*SAMPLE_W + SAMPLE_W-1],
                                    in_data[gi*SAMPLE_W +: SAMPLE_W-1]};
        end
    end
`endif

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_s1_pack
        assign w_s1_src[gi*SAMPLE_W +: SAMPLE_W] = w_s1_lane[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_dat  <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_sof  <= 1'b0;
            r_s1_mode <= MODE_1CH;
        end else begin
            r_s1_vld <= w_accept;
            r_s1_sof <= w_accept & r_sof_pend;
            if (w_accept) begin
                r_s1_dat  <= w_s1_src;
                r_s1_mode <= w_mode;
            end
        end
    end

    // ---------------- stage 2: de-interleave ----------------
    assign w_ch_cnt = 3'(ch_count(r_s1_mode));

    for (genvar gj = 0; gj < NUM_LANES; gj++) begin : g_reorder
        localparam int SRC2 = lane_src(gj, 2, NUM_LANES);
        localparam int SRC4 = lane_src(gj, 4, NUM_LANES);
        assign w_re_lane[gj] = (w_ch_cnt == 3'd1) ? r_s1_dat[gj*SAMPLE_W +: SAMPLE_W] :
                               (w_ch_cnt == 3'd2) ? r_s1_dat[SRC2*SAMPLE_W +: SAMPLE_W] :
                                                    r_s1_dat[SRC4*SAMPLE_W +: SAMPLE_W];
        assign w_reorder[gj*SAMPLE_W +: SAMPLE_W] = w_re_lane[gj];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_dat  <= '0;
            r_out_vld  <= 1'b0;
            r_out_sof  <= 1'b0;
            r_out_mode <= MODE_1CH;
        end else begin
            r_out_vld <= r_s1_vld;
            r_out_sof <= r_s1_vld & r_s1_sof;
            // Mode travels with its data so a change boundary never mislabels a beat.
            if (r_s1_vld) begin
                r_out_dat  <= w_reorder;
                r_out_mode <= r_s1_mode;
            end
        end
    end

    assign out_data     = r_out_dat;
    assign out_valid    = r_out_vld;
    assign out_sof      = r_out_sof;
    assign out_ch_mode  = r_out_mode;
    assign mode_changes = r_mode_cnt;

endmodule
